// File: rtl/trace_matcher_pkg.sv
// Shared constants, FSM encoding and helpers for the trace pattern matcher.
package trace_matcher_pkg;
  localparam logic [31:0] TRACE_FULL_SYNC   = 32'hFFFFFF7F;
  localparam int          TRACE_COUNT_WIDTH = 8;

  typedef enum logic {
    TM_UNSYNC = 1'b0,
    TM_SYNC   = 1'b1
  } tm_state_e;

  function automatic logic [TRACE_COUNT_WIDTH-1:0] sat_inc(input logic [TRACE_COUNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/trace_matcher_if.sv
// Deserialized TPIU byte stream into the matcher.
interface trace_matcher_if;
  logic [7:0] I_data;
  logic       I_data_valid;

  modport master (output I_data, output I_data_valid);
  modport slave  (input  I_data, input  I_data_valid);
endinterface

// File: rtl/trace_matcher_rule_match.sv
// One pattern/mask rule: masked compare into a registered hit bit plus a saturating hit counter.
module trace_rule_match
  import trace_matcher_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         clr_i,
  input  logic                         eval_i,
  input  logic                         en_i,
  input  logic [W-1:0]                 buf_i,
  input  logic [W-1:0]                 pattern_i,
  input  logic [W-1:0]                 mask_i,
  output logic                         hit_o,
  output logic                         hit_q_o,
  output logic [TRACE_COUNT_WIDTH-1:0] count_o
);
  logic                         hit_q;
  logic [TRACE_COUNT_WIDTH-1:0] count_q;

  assign hit_o   = en_i && (((buf_i ^ pattern_i) & mask_i) == '0);
  assign hit_q_o = hit_q;
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      hit_q   <= 1'b0;
      count_q <= '0;
    end else begin
      if (eval_i) hit_q <= hit_o;
      // Clear wins over an in-flight evaluation's increment.
      if (clr_i)                count_q <= '0;
      else if (eval_i && hit_o) count_q <= sat_inc(count_q);
    end
  end
endmodule

// File: rtl/trace_matcher.sv
// Byte-stream sync detector and pattern-matching stage of the trace trigger path.
module trace_matcher
  import trace_matcher_pkg::*;
#(
  parameter int pBUFFER_SIZE = 64,
  parameter int pMATCH_RULES = 8
) (
  input  logic                                      trace_clk,
  input  logic                                      reset_i,
  trace_matcher_if.slave                            stream_i,
  input  logic                                      I_reset_sync,
  input  logic [pMATCH_RULES-1:0]                   I_pattern_enable,
  input  logic [pMATCH_RULES-1:0]                   I_pattern_trig_enable,
  input  logic                                      I_trig_toggle,
  input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0]      I_trace_pattern,
  input  logic [pMATCH_RULES*pBUFFER_SIZE-1:0]      I_trace_mask,
  output logic [pMATCH_RULES-1:0]                   O_matching_pattern,
  output logic [pBUFFER_SIZE-1:0]                   O_matching_buffer,
  output logic                                      O_synchronized,
  output logic                                      O_trigger,
  output logic [pMATCH_RULES*TRACE_COUNT_WIDTH-1:0] O_trace_count
);
  localparam int FILL_MAX = pBUFFER_SIZE / 8;
  localparam int FW       = $clog2(FILL_MAX + 1);

  tm_state_e                state_q, state_d;
  logic [pBUFFER_SIZE-1:0]  buf_q, buf_d, mbuf_q;
  logic [FW-1:0]            fill_q, fill_d, fill_inc;
  logic                     sync_q, sync_d, eval_q, eval_d, trig_q, trig_d;
  logic                     full_sync, valid, trig_event;
  logic [pMATCH_RULES-1:0]  hit_vec;

  assign valid     = stream_i.I_data_valid;
  assign buf_d     = valid ? {buf_q[pBUFFER_SIZE-9:0], stream_i.I_data} : buf_q;
  assign full_sync = valid && (buf_d[31:0] == TRACE_FULL_SYNC);
  assign fill_inc  = (fill_q == FW'(FILL_MAX)) ? fill_q : fill_q + 1'b1;

  always_ff @(posedge trace_clk) begin
    if (reset_i) state_q <= TM_UNSYNC;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (I_reset_sync)   state_d = TM_UNSYNC;
    else if (full_sync) state_d = TM_SYNC;
  end

  // Evaluate only once the buffer has been completely refilled since the last sync word.
  always_comb begin
    sync_d = (state_q == TM_SYNC);
    eval_d = valid && (state_q == TM_SYNC) && !I_reset_sync && !full_sync &&
             (fill_inc == FW'(FILL_MAX));
  end

  always_comb begin
    fill_d = fill_q;
    if (valid && !I_reset_sync) begin
      if (full_sync)                fill_d = '0;
      else if (state_q == TM_SYNC)  fill_d = fill_inc;
    end
  end

  genvar g;
  generate
    for (g = 0; g < pMATCH_RULES; g++) begin : g_rule
      trace_rule_match #(.W(pBUFFER_SIZE)) u_rule (
        .clk       (trace_clk),
        .rst_i     (reset_i),
        .clr_i     (I_reset_sync),
        .eval_i    (eval_q),
        .en_i      (I_pattern_enable[g]),
        .buf_i     (buf_q),
        .pattern_i (I_trace_pattern[g*pBUFFER_SIZE +: pBUFFER_SIZE]),
        .mask_i    (I_trace_mask[g*pBUFFER_SIZE +: pBUFFER_SIZE]),
        .hit_o     (hit_vec[g]),
        .hit_q_o   (O_matching_pattern[g]),
        .count_o   (O_trace_count[g*TRACE_COUNT_WIDTH +: TRACE_COUNT_WIDTH])
      );
    end
  endgenerate

  assign trig_event = eval_q && ((hit_vec & I_pattern_trig_enable) != '0);
  assign trig_d     = I_trig_toggle ? (trig_q ^ trig_event) : trig_event;

  always_ff @(posedge trace_clk) begin
    if (reset_i) begin
      buf_q  <= '0;
      fill_q <= '0;
      sync_q <= 1'b0;
      eval_q <= 1'b0;
      trig_q <= 1'b0;
      mbuf_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
      sync_q <= sync_d;
      eval_q <= eval_d;
      trig_q <= trig_d;
      if (eval_q && (hit_vec != '0)) mbuf_q <= buf_q;
    end
  end

  assign O_synchronized    = sync_q;
  assign O_trigger         = trig_q;
  assign O_matching_buffer = mbuf_q;
endmodule
